// File: rtl/clockworks_pkg.sv
// Shared constants and helpers for the clock/reset generator.
// Holds the fast-sim stretch and divisor-shift values used under CLKGEN_FAST_SIM_EN.
package clockworks_pkg;

  localparam int FAST_SIM_STRETCH   = 4;
  localparam int FAST_SIM_DIV_SHIFT = 4;

  function automatic int stretch_cnt_w(input int rst_cycles);
    return $clog2(rst_cycles + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-release reset synchronizer followed by a stretch counter.
// resetn rises STRETCH cycles after the second sync flop sees RESETN released.
module reset_sync #(
  parameter int STRETCH = 16
) (
  input  logic CLK,
  input  logic RESETN,
  output logic resetn
);
  import clockworks_pkg::*;

  localparam int CW = stretch_cnt_w(STRETCH);

  logic [1:0]    sync_q;
  logic [CW-1:0] stretch_cnt;
  logic          rst_q;

  // Any RESETN assertion clears the count, so a mid-stretch glitch restarts it from zero
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q      <= '0;
      stretch_cnt <= '0;
      rst_q       <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      if (sync_q[1] && !rst_q) begin
        if (stretch_cnt == CW'(STRETCH - 1))
          rst_q <= 1'b1;
        else
          stretch_cnt <= stretch_cnt + 1'b1;
      end
    end
  end

  assign resetn = rst_q;

endmodule

// File: rtl/clock_reset_gen.sv
// Clock-enable / divided-clock generator with a stretched, synchronously released reset.
// Define CLKGEN_FAST_SIM_EN to shorten the reset stretch and scale down the reset divisor.
module clock_reset_gen #(
  parameter int          DIV_W      = 16,
  parameter int unsigned DIV_INIT   = 0,
  parameter int          RST_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_en,
  output logic             clk_div,
  output logic             resetn
);
  import clockworks_pkg::*;

`ifdef CLKGEN_FAST_SIM_EN
  localparam int               STRETCH   = FAST_SIM_STRETCH;
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DIV_INIT >> FAST_SIM_DIV_SHIFT);
`else
  localparam int               STRETCH   = RST_CYCLES;
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DIV_INIT);
`endif

  logic             rst_int;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] pend_div;
  logic             pend_valid;
  logic             terminal;
  logic             accept;

  reset_sync #(
    .STRETCH (STRETCH)
  ) u_reset_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .resetn (rst_int)
  );

  assign resetn   = rst_int;
  assign terminal = rst_int && (count == cur_div);
  assign accept   = div_valid && div_ready;
  assign clk_en   = terminal;

  // Divisor swaps only at a terminal count, when count restarts at zero, so no short period
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count      <= '0;
      cur_div    <= RESET_DIV;
      pend_div   <= '0;
      pend_valid <= 1'b0;
      div_ready  <= 1'b0;
      clk_div    <= 1'b0;
    end else if (!rst_int) begin
      count      <= '0;
      cur_div    <= RESET_DIV;
      pend_div   <= '0;
      pend_valid <= 1'b0;
      div_ready  <= 1'b0;
      clk_div    <= 1'b0;
    end else begin
      if (terminal) begin
        count   <= '0;
        clk_div <= ~clk_div;
      end else begin
        count <= count + 1'b1;
      end

      if (accept) begin
        pend_div   <= div_in;
        pend_valid <= 1'b1;
        div_ready  <= 1'b0;
      end else if (pend_valid && terminal) begin
        cur_div    <= pend_div;
        pend_valid <= 1'b0;
      end else if (!pend_valid && !div_ready) begin
        div_ready <= 1'b1;
      end
    end
  end

endmodule

// File: doc/clock_reset_gen.md
CLOCK_RESET_GEN -- requirements
Module: clock_reset_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: divisor and counter width.
REQ-002 SHALL have parameter DIV_INIT, default 0: divisor in force after reset.
REQ-003 SHALL have parameter RST_CYCLES, default 16: reset stretch length in CLK cycles, minimum 1.
REQ-004 SHALL have port CLK  in  1: the single clock; rising-edge only.
REQ-005 SHALL have port RESETN  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port div_in  in  DIV_W: requested divisor.
REQ-007 SHALL have port div_valid  in  1: div_in is valid this cycle.
REQ-008 SHALL have port div_ready  out  1: divisor update can be accepted.
REQ-009 SHALL have port clk_en  out  1: one-cycle tick, once per (div+1) CLK cycles.
REQ-010 SHALL have port clk_div  out  1: divided square wave, period 2*(div+1) CLK cycles.
REQ-011 SHALL have port resetn  out  1: stretched, synchronously released active-low design reset.

Function
REQ-012 SHALL assert resetn low asynchronously when RESETN goes low.
REQ-013 SHALL release RESETN through a 2-flop synchronizer, then count RST_CYCLES CLK cycles before driving resetn high.
REQ-014 SHALL restart the stretch count from zero if RESETN reasserts mid-stretch.
REQ-015 SHALL hold the divider counter, clk_en, clk_div and the pending update in reset while resetn is low.
REQ-016 SHALL increment the counter every cycle once resetn is high; at count == cur_div: counter becomes 0, clk_en = 1 for that cycle, and clk_div toggles on the next edge.
REQ-017 SHALL make a divisor of 0 give clk_en high every cycle and clk_div toggling every cycle.
REQ-018 SHALL accept an update on a cycle where div_valid && div_ready, latch div_in into a pending register and drive div_ready low.
REQ-019 SHALL load a pending divisor into cur_div only at a terminal count (the clk_en cycle), then raise div_ready on the following cycle; there SHALL be no glitch or short period.
REQ-020 SHALL apply an accepted update coinciding with a terminal count at the next terminal count, not the current one.
REQ-021 SHALL ignore div_valid while div_ready is low; no overwrite occurs.
REQ-022 SHALL hold div_ready low while resetn is low.
REQ-023 SHALL compare the counter against cur_div at full DIV_W width; the counter SHALL never exceed cur_div or wrap past 2^DIV_W-1.

Reset
REQ-024 SHALL take these values while RESETN is low: resetn=0, clk_en=0, clk_div=0, div_ready=0, counter=0, cur_div=DIV_INIT (or its fast-sim value), no pending update.
REQ-025 SHALL use only the asynchronous RESETN as its reset; all flops SHALL be asynchronously cleared.

Configuration
REQ-026 SHALL use macro CLKGEN_FAST_SIM_EN; when defined, the stretch SHALL be 4 cycles and the reset divisor SHALL be DIV_INIT>>4, the simulation speed-up.
REQ-027 SHALL use RST_CYCLES and DIV_INIT unchanged when CLKGEN_FAST_SIM_EN is undefined; runtime updates through div_in SHALL be unaffected either way.

Structure
REQ-028 SHALL place in a shared package clockworks_pkg: the fast-sim stretch constant (4), the fast-sim divisor shift (4), and the stretch-counter width function (clog2 of RST_CYCLES+1).
REQ-029 SHALL use one sub-module, reset_sync, for the 2-flop async-assert/sync-release synchronizer plus stretch counter; the divider and handshake SHALL live in the top module.

Verification
REQ-030 SHALL cover: RESETN low 3 cycles then high, RST_CYCLES=16 -> resetn rises 18 cycles after release (2 sync + 16); with CLKGEN_FAST_SIM_EN it rises after 6.
REQ-031 SHALL cover: DIV_INIT=4 -> clk_en high 1 cycle in every 5; clk_div period 10 cycles, 50% duty.
REQ-032 SHALL cover: div=0 -> clk_en constantly 1 and clk_div toggles every cycle.
REQ-033 SHALL cover: running at div=9, div_in=2 accepted mid-period -> div_ready low, current 10-cycle period completes, next clk_en gaps are 3 cycles, div_ready high 1 cycle after the switch.
REQ-034 SHALL cover: second div_valid (div_in=7) while div_ready low -> ignored; divisor stays at first accepted value.
REQ-035 SHALL cover: RESETN pulsed low at stretch count 10 -> resetn stays low and the full 2+16 count restarts; all outputs return to REQ-024 values immediately, not on a CLK edge.
